// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Brief    : Fetch port, data port and shared memory port of mem_arbiter.
// Revision : 1.0
// ============================================================================
interface mem_arbiter_if;
    // Instruction-fetch port
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;

    // Data port
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    // Shared memory port
    logic [31:0] mem_address;
    logic        mem_wren;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    logic        busy;

    // Arbiter side
    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_funct3, d_addr, d_wdata,
        input  mem_data_out,
        output i_gnt, i_rvalid, i_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_address, mem_wren, mem_funct3, mem_data_in,
        output busy
    );

    // Requester / memory side
    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_funct3, d_addr, d_wdata,
        output mem_data_out,
        input  i_gnt, i_rvalid, i_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_address, mem_wren, mem_funct3, mem_data_in,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Arbitrates a fetch port and a data port onto one memory port,
//            one transaction at a time, alternating on simultaneous requests.
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int MEM_LATENCY = 1
) (
    input  wire logic    clk,
    input  wire logic    reset,
    mem_arbiter_if.slave bus
);

    localparam int                 c_CNT_W    = $clog2(MEM_LATENCY + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MEM_LATENCY - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_own_d;      // last granted port; doubles as current owner
    logic               r_store;
    logic [31:0]        r_mem_address;
    logic [2:0]         r_mem_funct3;
    logic [31:0]        r_mem_data_in;
    logic [31:0]        r_i_rdata;
    logic [31:0]        r_d_rdata;

    logic               w_any_req;
    logic               w_grant_d;

    assign w_any_req = bus.i_req | bus.d_req;
    // On a tie the port that did not win last time goes next.
    assign w_grant_d = bus.d_req & ~(bus.i_req & r_own_d);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_IDLE;
            r_cnt         <= '0;
            r_own_d       <= 1'b1;
            r_store       <= 1'b0;
            r_mem_address <= '0;
            r_mem_funct3  <= '0;
            r_mem_data_in <= '0;
            r_i_rdata     <= '0;
            r_d_rdata     <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any_req) begin
                        r_state <= c_ISSUE;
                        r_own_d <= w_grant_d;
                        if (w_grant_d) begin
                            r_store       <= bus.d_we;
                            r_mem_address <= bus.d_addr;
                            r_mem_funct3  <= bus.d_funct3;
                            r_mem_data_in <= bus.d_we ? bus.d_wdata : 32'd0;
                        end else begin
                            r_store       <= 1'b0;
                            r_mem_address <= bus.i_addr;
                            r_mem_funct3  <= 3'b010;
                            r_mem_data_in <= 32'd0;
                        end
                    end
                end
                c_ISSUE: begin
                    r_state <= c_WAIT;
                    r_cnt   <= '0;
                end
                c_WAIT: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= c_RESP;
                        // Read data is valid only in the last WAIT cycle.
                        if (r_own_d) begin
                            r_d_rdata <= r_store ? 32'd0 : bus.mem_data_out;
                        end else begin
                            r_i_rdata <= bus.mem_data_out;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_RESP: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.i_gnt       = (r_state == c_ISSUE) & ~r_own_d;
    assign bus.d_gnt       = (r_state == c_ISSUE) &  r_own_d;
    assign bus.mem_wren    = (r_state == c_ISSUE) &  r_own_d & r_store;
    assign bus.i_rvalid    = (r_state == c_RESP)  & ~r_own_d;
    assign bus.d_rvalid    = (r_state == c_RESP)  &  r_own_d;
    assign bus.i_rdata     = r_i_rdata;
    assign bus.d_rdata     = r_d_rdata;
    assign bus.mem_address = r_mem_address;
    assign bus.mem_funct3  = r_mem_funct3;
    assign bus.mem_data_in = r_mem_data_in;
    assign bus.busy        = (r_state != c_IDLE);

endmodule
`default_nettype wire
